workgroup_read_arbiter: RTL and testbench
=========================================

WORKGROUP_READ_ARBITER -- requirements
Module: workgroup_read_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, address width of requesters and master port.
REQ-002 Parameter: DATA_W, default 512, read data width.
REQ-003 Parameter: MAX_OUT, default 4, maximum outstanding read bursts per requester, range 1..7.
REQ-004 Port: aclk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: aresetn  in  1  asynchronous, active-low reset.
REQ-006 Port: req_arvalid  in  4  per-requester read request valid.
REQ-007 Port: req_araddr  in  4xADDR_W  per-requester burst start address.
REQ-008 Port: req_arlen  in  4x8  per-requester AXI burst length (beats-1).
REQ-009 Port: req_arready  out  4  per-requester request accept, one-hot or zero.
REQ-010 Port: req_rvalid  out  4  per-requester read beat valid.
REQ-011 Port: req_rdata  out  DATA_W  read data, broadcast to all requesters.
REQ-012 Port: req_rlast  out  1  last beat of burst, broadcast.
REQ-013 Port: req_rready  in  4  per-requester read beat ready.
REQ-014 Port: m_arvalid/m_arready  out/in  1/1  master AR handshake.
REQ-015 Port: m_araddr, m_arlen, m_arid, m_arsize, m_arburst  out  ADDR_W, 8, 16, 3, 2  master AR payload.
REQ-016 Port: m_rvalid, m_rdata, m_rid, m_rlast  in  1, DATA_W, 16, 1  master R payload.
REQ-017 Port: m_rready  out  1  master R ready.
REQ-018 Port: busy  out  1  high while any burst is outstanding or an AR is pending.
REQ-019 Port: err_sticky  out  1  set on protocol error, cleared only by reset.

Function
REQ-020 FSM states IDLE and ISSUE; reset state IDLE.
REQ-021 Requester i eligible when req_arvalid[i]=1 and out_cnt[i] < MAX_OUT.
REQ-022 IDLE: round-robin grant among eligible requesters, searching from rr_ptr upward modulo 4.
REQ-023 IDLE with a grant g: req_arready[g]=1 for that cycle (combinational), araddr/arlen of g registered, g registered, next state ISSUE.
REQ-024 IDLE with no eligible requester: req_arready=0, stay IDLE.
REQ-025 ISSUE: m_arvalid=1, payload stable until m_arready=1; req_arready=0 throughout.
REQ-026 ISSUE with m_arready=1: out_cnt[g] increments, rr_ptr becomes (g+1) mod 4, next state IDLE.
REQ-027 Latency: grant in cycle N gives m_arvalid in cycle N+1; minimum spacing between AR issues is 2 cycles.
REQ-028 m_arid = {14'b0, g[1:0]}; m_arsize = 3'b110 (64 B); m_arburst = 2'b01 (INCR).
REQ-029 R routing: idx = m_rid[1:0]; req_rvalid[idx] = m_rvalid, all other req_rvalid bits 0; m_rready = req_rready[idx]; req_rdata/req_rlast pass through combinationally.
REQ-030 m_rvalid & m_rready & m_rlast decrements out_cnt[idx].
REQ-031 Increment and decrement of the same counter in one cycle: counter unchanged.
REQ-032 m_rvalid with m_rid[15:2] nonzero: all req_rvalid=0, m_rready=1 (beat dropped), err_sticky set.
REQ-033 Decrement with out_cnt[idx]=0: counter stays 0, err_sticky set.
REQ-034 Counters are 3 bits and never exceed MAX_OUT; a requester at MAX_OUT is skipped and rr_ptr is not advanced past a non-granted requester.
REQ-035 busy = (state==ISSUE) or any out_cnt nonzero.

Reset
REQ-036 While aresetn=0: state IDLE, rr_ptr=0, all out_cnt=0, registered AR payload=0, m_arvalid=0, req_arready=0, busy=0, err_sticky=0.
REQ-037 Reset asserted mid-burst or during ISSUE: AR request abandoned, counters cleared; R beats arriving after reset release with no outstanding burst set err_sticky.
REQ-038 First grant after reset release occurs no earlier than the first rising edge with aresetn=1.

Verification
REQ-039 All 4 requesters valid continuously, m_arready=1 -> grants 0,1,2,3,0 in order, m_arid 0,1,2,3,0, one AR every 2 cycles.
REQ-040 Requester 2 alone, m_arready held low 5 cycles -> m_arvalid high 5+1 cycles, m_araddr/m_arlen stable, req_arready[2] pulsed exactly once.
REQ-041 MAX_OUT=4, requester 1 issues 4 bursts with no R returned -> 5th request not granted; one rlast on m_rid=1 -> grant follows within 2 cycles.
REQ-042 R beat m_rid=3, req_rready[3]=0 -> m_rready=0, req_rvalid=4'b1000; rlast accepted in the same cycle as an AR accept for requester 3 -> out_cnt[3] unchanged.
REQ-043 m_rvalid with m_rid=16'h0004 -> m_rready=1, no req_rvalid, err_sticky=1 until reset.
REQ-044 aresetn pulsed low during ISSUE with 2 bursts outstanding -> m_arvalid=0 and busy=0 immediately, rr_ptr=0, next grant to lowest-index eligible requester.

Source files
------------

// File: rtl/workgroup_read_arbiter_if.sv
// Bus bundles for the workgroup read arbiter: the four-requester side and the AXI read master side.
// On each bundle the arbiter connects to one modport and the attached agent connects to the other.
interface wrd_req_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [3:0]             req_arvalid;
  logic [3:0][ADDR_W-1:0] req_araddr;
  logic [3:0][7:0]        req_arlen;
  logic [3:0]             req_arready;
  logic [3:0]             req_rvalid;
  logic [DATA_W-1:0]      req_rdata;
  logic                   req_rlast;
  logic [3:0]             req_rready;

  modport master (
    output req_arvalid, req_araddr, req_arlen, req_rready,
    input  req_arready, req_rvalid, req_rdata, req_rlast
  );
  modport slave (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
    output req_arready, req_rvalid, req_rdata, req_rlast
  );
endinterface

interface wrd_axi_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [15:0]       m_arid;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic [15:0]       m_rid;
  logic              m_rlast;
  logic              m_rready;

  modport master (
    output m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rid, m_rlast
  );
  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rid, m_rlast
  );
endinterface

// File: rtl/workgroup_read_arbiter.sv
// Round-robin arbiter merging four requesters' AXI read bursts onto one master port,
// with per-requester outstanding-burst limits and ID-based read data routing.
module workgroup_read_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 4
) (
  input  logic      aclk,
  input  logic      aresetn,
  wrd_req_if.slave  req,
  wrd_axi_if.master m,
  output logic      busy,
  output logic      err_sticky
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  state_e            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [3:0][2:0]   out_cnt_q, out_cnt_d;
  logic              err_q, err_d;

  logic [3:0]        elig_s;
  logic              grant_vld_s;
  logic [1:0]        grant_idx_s;
  logic              ar_hs_s;
  logic [1:0]        r_idx_s;
  logic              r_bad_id_s;
  logic              r_ready_s;
  logic              r_last_hs_s;
  logic [DATA_W-1:0] rdata_s;

  // Eligibility: request pending and room left for another outstanding burst
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = req.req_arvalid[i] && (out_cnt_q[i] < MAX_CNT);
    end
  end

  // Round-robin search starting at rr_ptr and wrapping modulo 4
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!grant_vld_s && elig_s[rr_ptr_q + 2'(k)]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = rr_ptr_q + 2'(k);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // AR FSM: grant in IDLE, hold the registered request on the master port in ISSUE
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    gnt_d           = gnt_q;
    araddr_d        = araddr_q;
    arlen_d         = arlen_q;
    ar_hs_s         = 1'b0;
    req.req_arready = 4'b0000;
    m.m_arvalid     = 1'b0;
    case (state_q)
      IDLE: begin
        // aresetn gating keeps the combinational accept quiet while held in reset
        if (grant_vld_s && aresetn) begin
          req.req_arready[grant_idx_s] = 1'b1;
          gnt_d    = grant_idx_s;
          araddr_d = req.req_araddr[grant_idx_s];
          arlen_d  = req.req_arlen[grant_idx_s];
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        m.m_arvalid = 1'b1;
        if (m.m_arready) begin
          ar_hs_s  = 1'b1;
          rr_ptr_d = gnt_q + 2'd1;
          state_d  = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m.m_araddr  = araddr_q;
  assign m.m_arlen   = arlen_q;
  assign m.m_arid    = {14'b0, gnt_q};
  assign m.m_arsize  = 3'b110;
  assign m.m_arburst = 2'b01;

  // R routing by the low ID bits; unknown IDs are swallowed so the master never stalls
  always_comb begin
    r_idx_s        = m.m_rid[1:0];
    r_bad_id_s     = |m.m_rid[15:2];
    req.req_rvalid = 4'b0000;
    if (r_bad_id_s) begin
      r_ready_s = 1'b1;
    end else begin
      req.req_rvalid[r_idx_s] = m.m_rvalid;
      r_ready_s               = req.req_rready[r_idx_s];
    end
    r_last_hs_s = m.m_rvalid && r_ready_s && m.m_rlast && !r_bad_id_s;
  end

  assign m.m_rready    = r_ready_s;
  assign rdata_s       = m.m_rdata;
  assign req.req_rdata = rdata_s;
  assign req.req_rlast = m.m_rlast;

  // Outstanding counters and sticky protocol error
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 4; i++) begin
      logic inc_s;
      logic dec_s;
      inc_s = ar_hs_s && (gnt_q == 2'(i));
      dec_s = r_last_hs_s && (r_idx_s == 2'(i));
      if (dec_s && (out_cnt_q[i] == 3'd0)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      if (inc_s && !dec_s) begin
        out_cnt_d[i] = out_cnt_q[i] + 3'd1;
      end else if (dec_s && !inc_s && (out_cnt_q[i] != 3'd0)) begin
        out_cnt_d[i] = out_cnt_q[i] - 3'd1;
      end else begin
        out_cnt_d[i] = out_cnt_q[i];
      end
    end
    if (m.m_rvalid && r_bad_id_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      gnt_q     <= 2'd0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign busy       = (state_q == ISSUE) || (|out_cnt_q);
  assign err_sticky = err_q;

endmodule

// File: tb/tb_workgroup_read_arbiter.sv
// Self-checking bench for workgroup_read_arbiter: R-routing vector table, directed
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_workgroup_read_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic busy, err_sticky;

  always #5 aclk = ~aclk;

  wrd_req_if #(.ADDR_W(AW), .DATA_W(DW)) rq ();
  wrd_axi_if #(.ADDR_W(AW), .DATA_W(DW)) ax ();

  workgroup_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req        (rq),
    .m          (ax),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    rq.req_arvalid = 4'b0000;
    rq.req_rready  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rq.req_araddr[i] = AW'(32'h1000 * (i + 1));
      rq.req_arlen[i]  = 8'(i + 3);
    end
    ax.m_arready = 1'b0;
    ax.m_rvalid  = 1'b0;
    ax.m_rdata   = '0;
    ax.m_rid     = 16'h0000;
    ax.m_rlast   = 1'b0;
  endtask

  // Holds reset for two cycles with all requesters asserting, checks reset outputs, releases at a negedge
  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    rq.req_arvalid = 4'b1111;
    next();
    #1;
    chk("rst_arready", 64'(rq.req_arready), 64'h0);
    chk("rst_arvalid", 64'(ax.m_arvalid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_sticky), 64'h0);
    chk("rst_araddr", 64'(ax.m_araddr), 64'h0);
    next();
    aresetn = 1'b1;
    rq.req_arvalid = 4'b0000;
  endtask

  typedef struct {
    logic        rvalid;
    logic [15:0] rid;
    logic [3:0]  rready;
    logic [3:0]  exp_rvalid;
    logic        exp_mrready;
  } rvec_t;

  rvec_t vecs[8];

  // transaction-level reference model state
  int   m_cnt[4];
  int   m_rr;
  bit   m_pend;
  int   m_pid;
  logic [AW-1:0] m_paddr;
  logic [7:0]    m_plen;
  bit   m_err;

  initial begin
    logic [63:0] d;
    int pulses, highs, seen;
    logic [AW-1:0] saddr;
    logic [7:0] slen;

    idle_inputs();
    next();

    // ---------------- R routing table ----------------
    vecs[0] = '{1'b1, 16'h0000, 4'b1111, 4'b0001, 1'b1};
    vecs[1] = '{1'b1, 16'h0001, 4'b0000, 4'b0010, 1'b0};
    vecs[2] = '{1'b1, 16'h0002, 4'b0100, 4'b0100, 1'b1};
    vecs[3] = '{1'b1, 16'h0003, 4'b0111, 4'b1000, 1'b0};
    vecs[4] = '{1'b0, 16'h0002, 4'b0100, 4'b0000, 1'b1};
    vecs[5] = '{1'b0, 16'h0001, 4'b1101, 4'b0000, 1'b0};
    vecs[6] = '{1'b1, 16'h0008, 4'b0000, 4'b0000, 1'b1};
    vecs[7] = '{1'b1, 16'h8003, 4'b1111, 4'b0000, 1'b1};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      d = {$urandom, $urandom};
      ax.m_rvalid   = vecs[v].rvalid;
      ax.m_rid      = vecs[v].rid;
      ax.m_rdata    = d;
      rq.req_rready = vecs[v].rready;
      #1;
      chk($sformatf("tbl%0d_rvalid", v), 64'(rq.req_rvalid), 64'(vecs[v].exp_rvalid));
      chk($sformatf("tbl%0d_mrready", v), 64'(ax.m_rready), 64'(vecs[v].exp_mrready));
      chk($sformatf("tbl%0d_rdata", v), rq.req_rdata, d);
      next();
    end

    // ---------------- round-robin with all requesters valid ----------------
    do_reset();
    rq.req_arvalid = 4'b1111;
    ax.m_arready   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_arready", k), 64'(rq.req_arready), 64'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_idle_arvalid", k), 64'(ax.m_arvalid), 64'h0);
      next();
      #1;
      chk($sformatf("rr%0d_arvalid", k), 64'(ax.m_arvalid), 64'h1);
      chk($sformatf("rr%0d_arid", k), 64'(ax.m_arid), 64'(k % 4));
      chk($sformatf("rr%0d_araddr", k), 64'(ax.m_araddr), 64'(32'h1000 * ((k % 4) + 1)));
      chk($sformatf("rr%0d_arlen", k), 64'(ax.m_arlen), 64'((k % 4) + 3));
      chk($sformatf("rr%0d_arsize", k), 64'(ax.m_arsize), 64'(3'b110));
      chk($sformatf("rr%0d_arburst", k), 64'(ax.m_arburst), 64'(2'b01));
      chk($sformatf("rr%0d_issue_arready", k), 64'(rq.req_arready), 64'h0);
      next();
    end

    // ---------------- requester 2 alone, master stalls 5 cycles ----------------
    do_reset();
    pulses = 0;
    highs  = 0;
    saddr  = '0;
    slen   = 8'd0;
    for (int t = 0; t < 8; t++) begin
      rq.req_arvalid = (t == 0) ? 4'b0100 : 4'b0000;
      ax.m_arready   = (t == 6);
      #1;
      if (rq.req_arready[2]) pulses++;
      if (ax.m_arvalid) begin
        highs++;
        if (highs == 1) begin
          saddr = ax.m_araddr;
          slen  = ax.m_arlen;
        end else begin
          chk("stall_addr_stable", 64'(ax.m_araddr), 64'(saddr));
          chk("stall_len_stable", 64'(ax.m_arlen), 64'(slen));
        end
      end
      next();
    end
    chk("stall_arready_pulses", 64'(pulses), 64'd1);
    chk("stall_arvalid_cycles", 64'(highs), 64'd6);
    chk("stall_addr_value", 64'(saddr), 64'h3000);

    // ---------------- MAX_OUT limit on requester 1 ----------------
    do_reset();
    rq.req_arvalid = 4'b0010;
    ax.m_arready   = 1'b1;
    for (int t = 0; t < 14; t++) begin
      #1;
      chk($sformatf("max_t%0d_arready", t), 64'(rq.req_arready),
          64'((t < 8 && (t % 2) == 0) ? 4'b0010 : 4'b0000));
      next();
    end
    ax.m_rvalid   = 1'b1;
    ax.m_rid      = 16'h0001;
    ax.m_rlast    = 1'b1;
    rq.req_rready = 4'b0010;
    #1;
    chk("max_rlast_mrready", 64'(ax.m_rready), 64'h1);
    chk("max_rlast_rvalid", 64'(rq.req_rvalid), 64'(4'b0010));
    next();
    ax.m_rvalid = 1'b0;
    ax.m_rlast  = 1'b0;
    seen = 0;
    for (int t = 0; t < 2; t++) begin
      #1;
      if (rq.req_arready == 4'b0010) seen = 1;
      next();
    end
    chk("max_regrant_after_rlast", 64'(seen), 64'd1);

    // ---------------- requester 3 back-pressure and simultaneous inc/dec ----------------
    do_reset();
    ax.m_rvalid    = 1'b1;
    ax.m_rid       = 16'h0003;
    rq.req_rready  = 4'b0111;
    rq.req_arvalid = 4'b1000;
    ax.m_arready   = 1'b1;
    #1;
    chk("bp3_mrready", 64'(ax.m_rready), 64'h0);
    chk("bp3_rvalid", 64'(rq.req_rvalid), 64'(4'b1000));
    chk("bp3_arready", 64'(rq.req_arready), 64'(4'b1000));
    next();
    ax.m_rvalid    = 1'b0;
    rq.req_arvalid = 4'b0000;
    next();
    rq.req_arvalid = 4'b1000;
    #1;
    chk("incdec_grant", 64'(rq.req_arready), 64'(4'b1000));
    next();
    rq.req_arvalid = 4'b0000;
    ax.m_rvalid    = 1'b1;
    ax.m_rlast     = 1'b1;
    rq.req_rready  = 4'b1000;
    #1;
    chk("incdec_arvalid", 64'(ax.m_arvalid), 64'h1);
    chk("incdec_mrready", 64'(ax.m_rready), 64'h1);
    next();
    ax.m_rvalid = 1'b0;
    #1;
    chk("incdec_busy_after", 64'(busy), 64'h1);
    chk("incdec_err_after", 64'(err_sticky), 64'h0);
    next();
    ax.m_rvalid = 1'b1;
    next();
    ax.m_rvalid = 1'b0;
    ax.m_rlast  = 1'b0;
    #1;
    chk("incdec_busy_drained", 64'(busy), 64'h0);
    chk("incdec_err_drained", 64'(err_sticky), 64'h0);
    next();

    // ---------------- bad upper ID bits ----------------
    do_reset();
    ax.m_rvalid   = 1'b1;
    ax.m_rid      = 16'h0004;
    ax.m_rlast    = 1'b1;
    rq.req_rready = 4'b0000;
    #1;
    chk("badid_mrready", 64'(ax.m_rready), 64'h1);
    chk("badid_rvalid", 64'(rq.req_rvalid), 64'h0);
    chk("badid_err_before", 64'(err_sticky), 64'h0);
    next();
    ax.m_rvalid = 1'b0;
    ax.m_rlast  = 1'b0;
    #1;
    chk("badid_err_set", 64'(err_sticky), 64'h1);
    repeat (3) next();
    #1;
    chk("badid_err_held", 64'(err_sticky), 64'h1);
    next();

    // ---------------- reset during ISSUE with two bursts outstanding ----------------
    do_reset();
    rq.req_arvalid = 4'b0011;
    ax.m_arready   = 1'b1;
    #1;
    chk("rstiss_g0", 64'(rq.req_arready), 64'(4'b0001));
    next();
    next();
    #1;
    chk("rstiss_g1", 64'(rq.req_arready), 64'(4'b0010));
    next();
    next();
    rq.req_arvalid = 4'b0100;
    ax.m_arready   = 1'b0;
    #1;
    chk("rstiss_g2", 64'(rq.req_arready), 64'(4'b0100));
    next();
    rq.req_arvalid = 4'b0000;
    #1;
    chk("rstiss_arvalid_pre", 64'(ax.m_arvalid), 64'h1);
    chk("rstiss_busy_pre", 64'(busy), 64'h1);
    aresetn = 1'b0;
    #1;
    chk("rstiss_arvalid_rst", 64'(ax.m_arvalid), 64'h0);
    chk("rstiss_busy_rst", 64'(busy), 64'h0);
    chk("rstiss_arready_rst", 64'(rq.req_arready), 64'h0);
    next();
    aresetn = 1'b1;
    rq.req_arvalid = 4'b1110;
    #1;
    chk("rstiss_lowest_grant", 64'(rq.req_arready), 64'(4'b0010));
    next();
    rq.req_arvalid = 4'b0000;
    ax.m_arready   = 1'b1;
    #1;
    chk("rstiss_arid", 64'(ax.m_arid), 64'h1);
    next();
    ax.m_arready  = 1'b0;
    ax.m_rvalid   = 1'b1;
    ax.m_rid      = 16'h0000;
    ax.m_rlast    = 1'b1;
    rq.req_rready = 4'b0001;
    next();
    ax.m_rvalid = 1'b0;
    ax.m_rlast  = 1'b0;
    #1;
    chk("rstiss_stale_rlast_err", 64'(err_sticky), 64'h1);
    next();

    // ---------------- randomized traffic vs. transaction model ----------------
    do_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_rr = 0; m_pend = 1'b0; m_pid = 0; m_paddr = '0; m_plen = 8'd0; m_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g, idx, inc_id, dec_id, nz, pick;
      bit bad, exp_mr;
      logic [3:0] exp_arr, exp_rv;
      rq.req_arvalid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        rq.req_araddr[i] = AW'($urandom);
        rq.req_arlen[i]  = 8'($urandom);
      end
      rq.req_rready = 4'($urandom);
      ax.m_arready  = 1'($urandom);
      ax.m_rdata    = {$urandom, $urandom};
      ax.m_rlast    = 1'($urandom);
      nz = 0;
      for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) nz++;
      ax.m_rvalid = (nz > 0) && ($urandom_range(0, 1) == 1);
      pick = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) if (m_cnt[(pick + i) % 4] > 0 && m_cnt[pick] == 0) pick = (pick + i) % 4;
      ax.m_rid = 16'(pick);
      if (cyc > 320 && $urandom_range(0, 40) == 0) begin
        ax.m_rvalid = 1'b1;
        ax.m_rid    = 16'h0010;
      end
      #1;
      g = -1;
      if (!m_pend) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_rr + k) % 4;
          if (g < 0 && rq.req_arvalid[c] && m_cnt[c] < MO) g = c;
        end
      end
      exp_arr = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      bad     = (ax.m_rid[15:2] != 14'd0);
      idx     = int'(ax.m_rid[1:0]);
      exp_rv  = (bad || !ax.m_rvalid) ? 4'b0000 : (4'b0001 << idx);
      exp_mr  = bad ? 1'b1 : rq.req_rready[idx];
      chk($sformatf("rnd%0d_arready", cyc), 64'(rq.req_arready), 64'(exp_arr));
      chk($sformatf("rnd%0d_arvalid", cyc), 64'(ax.m_arvalid), 64'(m_pend));
      if (m_pend) begin
        chk($sformatf("rnd%0d_arid", cyc), 64'(ax.m_arid), 64'(m_pid));
        chk($sformatf("rnd%0d_araddr", cyc), 64'(ax.m_araddr), 64'(m_paddr));
        chk($sformatf("rnd%0d_arlen", cyc), 64'(ax.m_arlen), 64'(m_plen));
      end
      chk($sformatf("rnd%0d_rvalid", cyc), 64'(rq.req_rvalid), 64'(exp_rv));
      chk($sformatf("rnd%0d_mrready", cyc), 64'(ax.m_rready), 64'(exp_mr));
      chk($sformatf("rnd%0d_busy", cyc), 64'(busy),
          64'(m_pend || m_cnt[0] > 0 || m_cnt[1] > 0 || m_cnt[2] > 0 || m_cnt[3] > 0));
      chk($sformatf("rnd%0d_err", cyc), 64'(err_sticky), 64'(m_err));
      inc_id = -1;
      if (m_pend) begin
        if (ax.m_arready) begin
          inc_id = m_pid;
          m_rr   = (m_pid + 1) % 4;
          m_pend = 1'b0;
        end
      end else if (g >= 0) begin
        m_pend  = 1'b1;
        m_pid   = g;
        m_paddr = rq.req_araddr[g];
        m_plen  = rq.req_arlen[g];
      end
      dec_id = (ax.m_rvalid && exp_mr && ax.m_rlast && !bad) ? idx : -1;
      if (ax.m_rvalid && bad) m_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
        int n;
        if (dec_id == i && m_cnt[i] == 0) m_err = 1'b1;
        n = m_cnt[i] + ((inc_id == i) ? 1 : 0) - ((dec_id == i) ? 1 : 0);
        m_cnt[i] = (n < 0) ? 0 : n;
      end
      next();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
